alu_sched: RTL and testbench
============================

# alu_sched

Two-port scheduler that shares the single combinational ALU between two requesters, for example the execute pipeline on port 0 and the address-generation path on port 1. Each port uses a valid/ready handshake. The block arbitrates between the ports and registers the winning operation into an issue stage. It drives the ALU's one-hot operation strobes from that stage, captures the ALU result into a response stage, and returns the result with its tag to the originating port.

## Interface
Parameters:
- TAG_W, default 4: width of the requester tag returned with each result.

Ports:
- clk, input, 1: clock. All logic is on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- flush, input, 1: synchronous discard of all in-flight operations.
- req_valid, input, [1:0]: per-port request valid.
- req_ready, output, [1:0]: per-port request accepted.
- req_op, input, [1:0][4:0]: per-port operation code, type alu_op_e.
- req_src1, req_src2, req_imm, req_pc, input, [1:0][31:0]: per-port operands.
- req_tag, input, [1:0][TAG_W-1:0]: per-port opaque tag.
- rsp_valid, output, [1:0]: result valid, asserted only toward the owning port.
- rsp_ready, input, [1:0]: per-port result accept.
- rsp_result, output, 32: result, shared by both ports.
- rsp_tag, output, TAG_W: tag of the result, shared by both ports.
- alu_src1, alu_src2, alu_imm, alu_pc, output, 32: ALU operands, driven directly from the issue register.
- alu_op_onehot, output, 25: ALU strobes; bit n drives the ALU strobe for the operation whose code is n.
- alu_result, input, 32: combinational ALU result.

## Operation
- Operation codes: ADDI=0, ADD=1, SUB=2, SLTU=3, SLTIU=4, SLT=5, SLTI=6, XOR=7, XORI=8, OR=9, ORI=10, AND=11, ANDI=12, SLL=13, SLLI=14, SRL=15, SRLI=16, SRA=17, SRAI=18, JAL=19, JALR=20, LUI=21, AUIPC=22, STORE=23, LOAD=24.
- Codes 25–31 are illegal. An illegal code produces alu_op_onehot=0, so the result is 0. The operation still completes normally.
- Two register stages:
  - ISS holds iss_valid, owner, op, operands and tag.
  - RSP holds rsp_v, owner, result and tag.
- rsp_adv = !rsp_v | rsp_ready[rsp_owner].
- iss_adv = !iss_valid | rsp_adv.
- Arbitration is combinational. The grant goes to the port with priority when it is valid, otherwise to the other valid port.
- req_ready[i] = grant[i] & iss_adv & !flush. At most one bit of req_ready is high in any cycle.
- On a handshake, ISS loads the granted request. If there is no handshake and iss_adv is high, iss_valid clears.
- When iss_valid & rsp_adv, RSP loads alu_result, the ISS owner and the ISS tag. If rsp_adv is high with no valid ISS, rsp_v clears.
- rsp_valid[i] = rsp_v & (rsp_owner==i).
- rsp_result and rsp_tag hold their value while not advancing. This holds even when rsp_v=0.
- Flush:
  - Clears iss_valid and rsp_v at the clock edge.
  - Blocks new acceptance in the same cycle.
  - Takes priority over a simultaneous handshake on the response side; no result is delivered for that cycle's acceptance.
  - Leaves the priority pointer unchanged.
- Reset values:
  - iss_valid=0 and rsp_v=0.
  - Priority pointer on port 0.
  - All data registers 0.
  - As a result alu_op_onehot=0, rsp_result=0, rsp_tag=0, req_ready=0 and rsp_valid=0 on the first cycle after reset.
- Reset asserted in the middle of an operation discards all state, exactly as for reset from idle.

## Timing
- A request accepted at edge T appears at the ALU inputs in cycle T+1. rsp_valid is high in cycle T+2. Latency is 2 cycles.
- Throughput is one operation per cycle while the owner's rsp_ready stays high.
- If rsp_ready is held low, both stages fill. The block then accepts nothing more until the response drains, so at most 2 operations are outstanding.
- A response draining at the same edge as a new acceptance is legal and loses no cycle.
- The ALU path from ISS to RSP is exactly one cycle, with no combinational path from req_* to alu_*.
- req_ready depends combinationally on req_valid, rsp_ready and flush.

## Configuration
- ALU_SCHED_RR_EN defined: round-robin arbitration. After each handshake on port i, priority moves to port 1-i. With no handshake, priority is unchanged.
- ALU_SCHED_RR_EN undefined: fixed priority, port 0 always wins. The pointer register is removed.

## Structure
- The package alu_sched_pkg holds:
  - the alu_op_e enum (5 bits, values above);
  - ALU_NOPS=25;
  - the iss_t and rsp_t packed structs.
- One sub-module, alu_op_decode: combinational conversion from alu_op_e to the 25-bit one-hot strobes, giving zero for illegal codes.
- The ALU itself is instantiated by the parent, outside this block.

## Test plan
- Basic latency: after reset, port 0 sends ADD with 5 and 7 and tag 3 at T. Required: alu_op_onehot=1<<1 at T+1; rsp_valid=2'b01, rsp_result=12, rsp_tag=3 at T+2.
- Round-robin (macro defined): both ports valid continuously, port 0 sending SUB 10−3 and port 1 sending XORI 0xF0^0x0F. Required: grants alternate 0,1,0,1 starting with port 0; results 7 and 0xFF alternate on the matching rsp_valid bit.
- Fixed priority (macro undefined): same stimulus as the round-robin test. Required: port 1 is never granted while port 0 is valid.
- Backpressure: port 1 rsp_ready=0 while 3 SLT requests (−1<1) are sent back-to-back. Required:
  - 2 accepted, then req_ready=0;
  - rsp_result=1 held stable;
  - releasing rsp_ready drains both results one per cycle.
- Flush: flush asserted while both stages are full and port 0 is valid. Required: rsp_valid=0 the next cycle, no acceptance in the flush cycle, and the pointer unchanged.
- Illegal code: op=27 with src1=0xFFFF_FFFF. Required: alu_op_onehot=0 and rsp_result=0 two cycles after acceptance. Reset asserted mid-stream returns every output to its reset value.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the two-port ALU scheduler.
package alu_sched_pkg;

    localparam int unsigned ALU_NOPS = 25;

    typedef enum logic [4:0] {
        OP_ADDI  = 5'd0,
        OP_ADD   = 5'd1,
        OP_SUB   = 5'd2,
        OP_SLTU  = 5'd3,
        OP_SLTIU = 5'd4,
        OP_SLT   = 5'd5,
        OP_SLTI  = 5'd6,
        OP_XOR   = 5'd7,
        OP_XORI  = 5'd8,
        OP_OR    = 5'd9,
        OP_ORI   = 5'd10,
        OP_AND   = 5'd11,
        OP_ANDI  = 5'd12,
        OP_SLL   = 5'd13,
        OP_SLLI  = 5'd14,
        OP_SRL   = 5'd15,
        OP_SRLI  = 5'd16,
        OP_SRA   = 5'd17,
        OP_SRAI  = 5'd18,
        OP_JAL   = 5'd19,
        OP_JALR  = 5'd20,
        OP_LUI   = 5'd21,
        OP_AUIPC = 5'd22,
        OP_STORE = 5'd23,
        OP_LOAD  = 5'd24
    } alu_op_e;

    // Op is kept as raw bits so illegal codes 25..31 can be carried through.
    typedef struct packed {
        logic        valid;
        logic        owner;
        logic [4:0]  op;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] imm;
        logic [31:0] pc;
    } iss_t;

    typedef struct packed {
        logic        valid;
        logic        owner;
        logic [31:0] result;
    } rsp_t;

endpackage

// File: rtl/alu_op_decode.sv
// Operation code to one-hot ALU strobe conversion; illegal codes give all zeros.
module alu_op_decode
    import alu_sched_pkg::*;
(
    input  logic [4:0]          op_i,
    output logic [ALU_NOPS-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int unsigned n = 0; n < ALU_NOPS; n++) begin
            onehot_o[n] = (op_i == 5'(n));
        end
    end

endmodule

// File: rtl/alu_sched.sv
// Two-port scheduler sharing one combinational ALU through ISS and RSP register stages.
// Define ALU_SCHED_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int unsigned TAG_W = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  flush_i,
    input  logic [1:0]            req_valid_i,
    output logic [1:0]            req_ready_o,
    input  logic [1:0][4:0]       req_op_i,
    input  logic [1:0][31:0]      req_src1_i,
    input  logic [1:0][31:0]      req_src2_i,
    input  logic [1:0][31:0]      req_imm_i,
    input  logic [1:0][31:0]      req_pc_i,
    input  logic [1:0][TAG_W-1:0] req_tag_i,
    output logic [1:0]            rsp_valid_o,
    input  logic [1:0]            rsp_ready_i,
    output logic [31:0]           rsp_result_o,
    output logic [TAG_W-1:0]      rsp_tag_o,
    output logic [31:0]           alu_src1_o,
    output logic [31:0]           alu_src2_o,
    output logic [31:0]           alu_imm_o,
    output logic [31:0]           alu_pc_o,
    output logic [ALU_NOPS-1:0]   alu_op_onehot_o,
    input  logic [31:0]           alu_result_i
);

    iss_t                iss_q, iss_d;
    rsp_t                rsp_q, rsp_d;
    logic [TAG_W-1:0]    iss_tag_q, iss_tag_d;
    logic [TAG_W-1:0]    rsp_tag_q, rsp_tag_d;
    logic                prio;
    logic [1:0]          grant;
    logic                rsp_adv, iss_adv, hs, sel;
    logic [ALU_NOPS-1:0] dec_onehot;

`ifdef ALU_SCHED_RR_EN
    logic prio_q, prio_d;

    // Priority flips to the other port only on an actual handshake.
    always_comb prio_d = hs ? ~sel : prio_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) prio_q <= 1'b0;
        else         prio_q <= prio_d;
    end

    assign prio = prio_q;
`else
    assign prio = 1'b0;
`endif

    always_comb begin
        grant = 2'b00;
        if (req_valid_i[prio])       grant[prio]  = 1'b1;
        else if (req_valid_i[!prio]) grant[!prio] = 1'b1;
    end

    assign rsp_adv     = !rsp_q.valid | rsp_ready_i[rsp_q.owner];
    assign iss_adv     = !iss_q.valid | rsp_adv;
    assign req_ready_o = grant & {2{iss_adv & !flush_i}};
    assign hs          = |req_ready_o;
    assign sel         = req_ready_o[1];

    always_comb begin
        iss_d     = iss_q;
        iss_tag_d = iss_tag_q;
        if (hs) begin
            iss_d.valid = 1'b1;
            iss_d.owner = sel;
            iss_d.op    = req_op_i[sel];
            iss_d.src1  = req_src1_i[sel];
            iss_d.src2  = req_src2_i[sel];
            iss_d.imm   = req_imm_i[sel];
            iss_d.pc    = req_pc_i[sel];
            iss_tag_d   = req_tag_i[sel];
        end else if (iss_adv) begin
            iss_d.valid = 1'b0;
        end
        if (flush_i) iss_d.valid = 1'b0;
    end

    // Result and tag only move on a real transfer so they stay stable while idle.
    always_comb begin
        rsp_d     = rsp_q;
        rsp_tag_d = rsp_tag_q;
        if (rsp_adv) begin
            rsp_d.valid = iss_q.valid;
            if (iss_q.valid) begin
                rsp_d.owner  = iss_q.owner;
                rsp_d.result = alu_result_i;
                rsp_tag_d    = iss_tag_q;
            end
        end
        if (flush_i) rsp_d.valid = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            iss_q     <= '0;
            iss_tag_q <= '0;
            rsp_q     <= '0;
            rsp_tag_q <= '0;
        end else begin
            iss_q     <= iss_d;
            iss_tag_q <= iss_tag_d;
            rsp_q     <= rsp_d;
            rsp_tag_q <= rsp_tag_d;
        end
    end

    alu_op_decode u_decode (
        .op_i     (iss_q.op),
        .onehot_o (dec_onehot)
    );

    assign alu_op_onehot_o = iss_q.valid ? dec_onehot : '0;
    assign alu_src1_o      = iss_q.src1;
    assign alu_src2_o      = iss_q.src2;
    assign alu_imm_o       = iss_q.imm;
    assign alu_pc_o        = iss_q.pc;

    assign rsp_valid_o  = {rsp_q.valid & rsp_q.owner, rsp_q.valid & !rsp_q.owner};
    assign rsp_result_o = rsp_q.result;
    assign rsp_tag_o    = rsp_tag_q;

endmodule

// File: tb/tb_alu_sched.sv
// Directed self-checking bench for alu_sched with a small behavioural ALU model.
module tb_alu_sched;

    localparam int unsigned TAG_W = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  flush;
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0][4:0]       req_op;
    logic [1:0][31:0]      req_src1, req_src2, req_imm, req_pc;
    logic [1:0][TAG_W-1:0] req_tag;
    logic [1:0]            rsp_valid;
    logic [1:0]            rsp_ready;
    logic [31:0]           rsp_result;
    logic [TAG_W-1:0]      rsp_tag;
    logic [31:0]           alu_src1, alu_src2, alu_imm, alu_pc;
    logic [24:0]           alu_op_onehot;
    logic [31:0]           alu_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_sched #(.TAG_W(TAG_W)) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .flush_i         (flush),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_op_i        (req_op),
        .req_src1_i      (req_src1),
        .req_src2_i      (req_src2),
        .req_imm_i       (req_imm),
        .req_pc_i        (req_pc),
        .req_tag_i       (req_tag),
        .rsp_valid_o     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .rsp_result_o    (rsp_result),
        .rsp_tag_o       (rsp_tag),
        .alu_src1_o      (alu_src1),
        .alu_src2_o      (alu_src2),
        .alu_imm_o       (alu_imm),
        .alu_pc_o        (alu_pc),
        .alu_op_onehot_o (alu_op_onehot),
        .alu_result_i    (alu_result)
    );

    // Subset of the ALU sufficient for the directed vectors below.
    always_comb begin
        alu_result = 32'h0;
        if (alu_op_onehot[0]) alu_result = alu_src1 + alu_imm;
        if (alu_op_onehot[1]) alu_result = alu_src1 + alu_src2;
        if (alu_op_onehot[2]) alu_result = alu_src1 - alu_src2;
        if (alu_op_onehot[3]) alu_result = {31'h0, alu_src1 < alu_src2};
        if (alu_op_onehot[5]) alu_result = {31'h0, $signed(alu_src1) < $signed(alu_src2)};
        if (alu_op_onehot[7]) alu_result = alu_src1 ^ alu_src2;
        if (alu_op_onehot[8]) alu_result = alu_src1 ^ alu_imm;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic [4:0] op, input logic [31:0] s1,
                           input logic [31:0] s2, input logic [31:0] imm,
                           input logic [TAG_W-1:0] tag);
        req_op[p]   = op;
        req_src1[p] = s1;
        req_src2[p] = s2;
        req_imm[p]  = imm;
        req_pc[p]   = 32'h100;
        req_tag[p]  = tag;
    endtask

    function automatic logic [1:0] exp_grant(input int k);
`ifdef ALU_SCHED_RR_EN
        return (k % 2 == 0) ? 2'b01 : 2'b10;
`else
        return 2'b01;
`endif
    endfunction

    initial begin
        logic [1:0] g;
        reset     = 1'b1;
        flush     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        set_req(0, 5'd0, 32'h0, 32'h0, 32'h0, 4'h0);
        set_req(1, 5'd0, 32'h0, 32'h0, 32'h0, 4'h0);
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_onehot", 32'(alu_op_onehot), 32'h0);
        chk("rst_result", rsp_result, 32'h0);
        chk("rst_tag", 32'(rsp_tag), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);

        // Basic latency: ADD 5+7 tag 3 on port 0.
        set_req(0, 5'd1, 32'd5, 32'd7, 32'h0, 4'd3);
        req_valid = 2'b01;
        #1;
        chk("lat_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 2'b00;
        #1;
        chk("lat_onehot", 32'(alu_op_onehot), 32'h2);
        chk("lat_src1", alu_src1, 32'd5);
        chk("lat_src2", alu_src2, 32'd7);
        chk("lat_rsp_early", 32'(rsp_valid), 32'h0);
        step();
        chk("lat_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("lat_result", rsp_result, 32'd12);
        chk("lat_tag", 32'(rsp_tag), 32'd3);
        step();
        chk("lat_rsp_clear", 32'(rsp_valid), 32'h0);
        chk("lat_result_hold", rsp_result, 32'd12);

        // Arbitration: both ports valid continuously from a fresh pointer.
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_req(0, 5'd2, 32'd10, 32'd3, 32'h0, 4'd5);
        set_req(1, 5'd8, 32'hF0, 32'h0, 32'h0F, 4'd9);
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("arb_grant", 32'(req_ready), 32'(exp_grant(k)));
            if (k >= 2) begin
                g = exp_grant(k - 2);
                chk("arb_rsp_valid", 32'(rsp_valid), 32'(g));
                chk("arb_result", rsp_result, g[0] ? 32'd7 : 32'hFF);
                chk("arb_tag", 32'(rsp_tag), g[0] ? 32'd5 : 32'd9);
            end
            step();
        end
        req_valid = 2'b00;
        step();
        step();

        // Backpressure: port 1 stalls, SLT -1 < 1 sent three times.
        rsp_ready = 2'b01;
        set_req(1, 5'd5, 32'hFFFF_FFFF, 32'd1, 32'h0, 4'd0);
        req_valid = 2'b10;
        #1;
        chk("bp_acc0", 32'(req_ready), 32'h2);
        step();
        req_tag[1] = 4'd1;
        #1;
        chk("bp_acc1", 32'(req_ready), 32'h2);
        step();
        req_tag[1] = 4'd2;
        #1;
        chk("bp_full", 32'(req_ready), 32'h0);
        chk("bp_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("bp_result", rsp_result, 32'd1);
        chk("bp_tag", 32'(rsp_tag), 32'd0);
        step();
        chk("bp_full2", 32'(req_ready), 32'h0);
        chk("bp_result_hold", rsp_result, 32'd1);
        chk("bp_tag_hold", 32'(rsp_tag), 32'd0);
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        step();
        chk("bp_drain1_valid", 32'(rsp_valid), 32'h2);
        chk("bp_drain1_tag", 32'(rsp_tag), 32'd1);
        chk("bp_drain1_result", rsp_result, 32'd1);
        step();
        chk("bp_drained", 32'(rsp_valid), 32'h0);

        // Flush with both stages full from port 0; pointer then favours port 1 under RR.
        rsp_ready = 2'b10;
        set_req(0, 5'd1, 32'd1, 32'd1, 32'h0, 4'd4);
        req_valid = 2'b01;
        #1;
        chk("fl_acc0", 32'(req_ready), 32'h1);
        step();
        chk("fl_acc1", 32'(req_ready), 32'h1);
        step();
        rsp_ready = 2'b11;
        flush     = 1'b1;
        #1;
        chk("fl_block", 32'(req_ready), 32'h0);
        step();
        flush     = 1'b0;
        req_valid = 2'b00;
        #1;
        chk("fl_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("fl_onehot", 32'(alu_op_onehot), 32'h0);
        req_valid = 2'b11;
        #1;
`ifdef ALU_SCHED_RR_EN
        chk("fl_prio_kept", 32'(req_ready), 32'h2);
`else
        chk("fl_prio_kept", 32'(req_ready), 32'h1);
`endif
        step();
        req_valid = 2'b00;
        step();
        step();

        // Illegal code 27 gives no strobe and a zero result.
        set_req(0, 5'd27, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 4'd6);
        req_valid = 2'b01;
        #1;
        chk("ill_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 2'b00;
        #1;
        chk("ill_onehot", 32'(alu_op_onehot), 32'h0);
        step();
        chk("ill_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("ill_result", rsp_result, 32'h0);
        chk("ill_tag", 32'(rsp_tag), 32'd6);

        // Reset in the middle of traffic.
        set_req(0, 5'd1, 32'd5, 32'd7, 32'h0, 4'd3);
        req_valid = 2'b01;
        step();
        step();
        req_valid = 2'b00;
        reset     = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("mrst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("mrst_onehot", 32'(alu_op_onehot), 32'h0);
        chk("mrst_result", rsp_result, 32'h0);
        chk("mrst_tag", 32'(rsp_tag), 32'h0);
        chk("mrst_ready", 32'(req_ready), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
